// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder
//  Purpose  : Memory-side CBus responder backed by an on-chip RAM. Accepts
//             one request at a time from the CBus arbiter and serves single
//             or burst reads/writes. The first ready beat arrives after a
//             programmable latency, and a programmable gap can separate
//             consecutive beats. Protocol violations by the master set a
//             sticky error flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_WORDS        RAM depth in 64-bit words (power of two, >= 2)
//    LATENCY          idle cycles between acceptance and first beat (0..15)
//    BEAT_GAP         ready-low cycles between consecutive beats (0..7)
//  Ports
//    clk_i            clock, all state on the rising edge
//    rst_ni           asynchronous active-low reset
//    creq_valid_i     request valid, held by the master until the last beat
//    creq_is_write_i  1 = write, 0 = read
//    creq_size_i      transfer size (latched, not used for byte masking)
//    creq_addr_i      byte address; bits [31:3] select the 64-bit word
//    creq_strobe_i    per-byte write enable for the current beat
//    creq_data_i      write data for the current beat
//    creq_len_i       number of beats minus one
//    creq_burst_i     burst type: 2'b01 = INCR, any other value = FIXED
//    cresp_ready_o    beat transfers in a cycle with ready high
//    cresp_last_o     marks the final beat of the transaction
//    cresp_data_o     read data (zero on writes and outside beats)
//    err_o            sticky protocol-violation flag
// ============================================================================
module cbus_ram_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int BEAT_GAP  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        creq_valid_i,
  input  logic        creq_is_write_i,
  input  logic [2:0]  creq_size_i,
  input  logic [31:0] creq_addr_i,
  input  logic [7:0]  creq_strobe_i,
  input  logic [63:0] creq_data_i,
  input  logic [7:0]  creq_len_i,
  input  logic [1:0]  creq_burst_i,
  output logic        cresp_ready_o,
  output logic        cresp_last_o,
  output logic [63:0] cresp_data_o,
  output logic        err_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_idx_w      = $clog2(MEM_WORDS);
  localparam logic [1:0]  c_burst_incr = 2'b01;
  localparam logic [3:0]  c_latency    = 4'(LATENCY);
  localparam logic [2:0]  c_beat_gap   = 3'(BEAT_GAP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_BEAT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic [3:0]  wait_q,     wait_d;
  logic [2:0]  gap_q,      gap_d;
  logic [7:0]  beat_q,     beat_d;
  logic [28:0] addr_q,     addr_d;      // word address, addr[31:3]
  logic [7:0]  len_q,      len_d;
  logic [1:0]  burst_q,    burst_d;
  logic        is_write_q, is_write_d;
  logic [2:0]  size_q,     size_d;
  logic        err_q,      err_d;

  logic [63:0] mem_q [MEM_WORDS];

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic               w_incr;
  logic [c_idx_w-1:0] w_beat_off;
  logic [c_idx_w-1:0] w_idx;
  logic               w_last;
  logic               w_active;
  logic               w_mismatch;
  logic               w_in_beat;
  logic               w_we;
  logic [63:0]        w_rdata;
  logic               w_unused_bits;

  assign w_incr     = (burst_q == c_burst_incr);
  // Beat offset only advances the address for INCR bursts; FIXED bursts
  // keep hitting the same word. The index wraps naturally at the RAM top.
  assign w_beat_off = w_incr ? c_idx_w'(beat_q) : '0;
  assign w_idx      = addr_q[c_idx_w-1:0] + w_beat_off;
  assign w_last     = (beat_q == len_q);
  assign w_in_beat  = (state_q == S_BEAT);

  // States in which the master must keep valid and the command stable.
  assign w_active   = (state_q == S_WAIT) || (state_q == S_BEAT) ||
                      (state_q == S_GAP);

  assign w_mismatch = (creq_addr_i[31:3] != addr_q)   ||
                      (creq_len_i        != len_q)    ||
                      (creq_burst_i      != burst_q)  ||
                      (creq_is_write_i   != is_write_q);

  // A write beat is only committed while the master still presents valid;
  // an aborting master leaves memory untouched in that cycle.
  assign w_we       = w_in_beat && is_write_q && creq_valid_i;

  assign w_rdata    = mem_q[w_idx];

  // Size is carried with the command for completeness but never masks data,
  // and the byte offset within a word is irrelevant to a 64-bit RAM.
  assign w_unused_bits = ^{size_q, creq_addr_i[2:0]};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    gap_d      = gap_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    is_write_d = is_write_q;
    size_d     = size_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (creq_valid_i) begin
          addr_d     = creq_addr_i[31:3];
          len_d      = creq_len_i;
          burst_d    = creq_burst_i;
          is_write_d = creq_is_write_i;
          size_d     = creq_size_i;
          beat_d     = 8'd0;
          wait_d     = c_latency;
          state_d    = (c_latency != 4'd0) ? S_WAIT : S_BEAT;
        end
      end

      S_WAIT: begin
        // wait_q counts the WAIT cycles still to spend including this one.
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = S_BEAT;
        end
      end

      S_BEAT: begin
        if (w_last) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 8'd1;
          if (c_beat_gap != 3'd0) begin
            gap_d   = c_beat_gap;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q - 3'd1;
        if (gap_q <= 3'd1) begin
          state_d = S_BEAT;
        end
      end

      S_DONE: begin
        // The arbiter's valid is still high for one cycle after last;
        // ignoring it here keeps it from launching a phantom transaction.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Master misbehaviour while a transaction is in flight. Dropping valid
    // aborts the transaction; changing the command is flagged but the
    // latched command keeps driving the remaining beats.
    if (w_active) begin
      if (!creq_valid_i) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else if (w_mismatch) begin
        err_d   = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      gap_q      <= 3'd0;
      beat_q     <= 8'd0;
      addr_q     <= 29'd0;
      len_q      <= 8'd0;
      burst_q    <= 2'd0;
      is_write_q <= 1'b0;
      size_q     <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      gap_q      <= gap_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      err_q      <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM: byte-strobed write port, no reset on contents
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (creq_strobe_i[b]) begin
          mem_q[w_idx][b*8 +: 8] <= creq_data_i[b*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs: decoded straight from the state register so that an
  // asynchronous reset drops them immediately.
  // --------------------------------------------------------------------------
  assign cresp_ready_o = w_in_beat;
  assign cresp_last_o  = w_in_beat && w_last;
  assign cresp_data_o  = (w_in_beat && !is_write_q) ? w_rdata : 64'd0;
  assign err_o         = err_q;

endmodule
`default_nettype wire
